// File: rtl/seven_seg_capture_pkg.sv
// Shared constants, FSM state type and anode helpers for the seven-segment capture block.
package seven_seg_capture_pkg;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SegPat0     = 7'h3F;
   localparam logic [6:0] SegPat1     = 7'h06;
   localparam logic [6:0] SegPat2     = 7'h5B;
   localparam logic [6:0] SegPat3     = 7'h4F;
   localparam logic [6:0] SegPat4     = 7'h66;
   localparam logic [6:0] SegPat5     = 7'h6D;
   localparam logic [6:0] SegPat6     = 7'h7D;
   localparam logic [6:0] SegPat7     = 7'h07;
   localparam logic [6:0] SegPat8     = 7'h7F;
   localparam logic [6:0] SegPat9     = 7'h6F;
   localparam logic [6:0] SegPatBlank = 7'h00;

   localparam logic [3:0] NibBlank = 4'hA;
   localparam logic [3:0] NibErr   = 4'hF;

   typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-high segment pattern to a BCD nibble (blank = 0xA, bad = 0xF).
module seg_pattern_decode
   import seven_seg_capture_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nib_o
);

   always_comb begin
      nib_o = NibErr;
      case (seg_i)
         SegPat0:     nib_o = 4'd0;
         SegPat1:     nib_o = 4'd1;
         SegPat2:     nib_o = 4'd2;
         SegPat3:     nib_o = 4'd3;
         SegPat4:     nib_o = 4'd4;
         SegPat5:     nib_o = 4'd5;
         SegPat6:     nib_o = 4'd6;
         SegPat7:     nib_o = 4'd7;
         SegPat8:     nib_o = 4'd8;
         SegPat9:     nib_o = 4'd9;
         SegPatBlank: nib_o = NibBlank;
         default:     nib_o = NibErr;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit seven-segment display into BCD frames.
// Define SEVEN_SEG_CAPTURE_ERR_EN to enable the sticky pattern_err flag.
module seven_seg_capture
   import seven_seg_capture_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic        dp_in,
   input  logic [3:0]  an_in,
   output logic [15:0] bcd,
   output logic [3:0]  dp_mask,
   output logic        frame_valid,
   output logic        pattern_err
);

   localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

   logic [6:0]      seg_s1_q, seg_s2_q;
   logic            dp_s1_q, dp_s2_q;
   logic [3:0]      an_s1_q, an_s2_q;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW:0]   cnt_inc;
   logic [11:0]     rec_q, rec_d;
   logic [15:0]     shadow_q, shadow_d;
   logic [3:0]      dps_q, dps_d;
   logic [3:0]      captured_q, captured_d;
   logic [15:0]     bcd_q, bcd_d;
   logic [3:0]      dpm_q, dpm_d;
   logic            fv_q, fv_d;

   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [11:0] sample;
   logic        sel, restart, accept;
   logic [1:0]  slot;
   logic [3:0]  nib;

   assign an_n    = AN_ACTIVE_LOW  ? ~an_s2_q  : an_s2_q;
   assign seg_n   = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
   assign dp_n    = SEG_ACTIVE_LOW ? ~dp_s2_q  : dp_s2_q;
   assign sample  = {an_n, seg_n, dp_n};
   assign sel     = is_onehot4(an_n);
   assign slot    = onehot_idx(an_n);
   assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};

   seg_pattern_decode u_decode (
      .seg_i (seg_n),
      .nib_o (nib)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rec_d   = rec_q;
      restart = 1'b0;
      accept  = 1'b0;
      case (state_q)
         StIdle: restart = sel;
         StSettle: begin
            if (sample == rec_q) begin
               if (cnt_q != CntMax) cnt_d = cnt_inc[CntW-1:0];
               if (cnt_inc >= {1'b0, CntMax}) begin
                  accept  = 1'b1;
                  state_d = StHeld;
               end
            end else if (sel) begin
               restart = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StHeld: begin
            if (sample != rec_q) begin
               if (sel) restart = 1'b1;
               else     state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A new select sample counts as the first of its run
      if (restart) begin
         cnt_d = CntW'(1);
         rec_d = sample;
         if (STABLE_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = StHeld;
         end else begin
            state_d = StSettle;
         end
      end
   end

   always_comb begin
      shadow_d   = shadow_q;
      dps_d      = dps_q;
      captured_d = captured_q;
      bcd_d      = bcd_q;
      dpm_d      = dpm_q;
      fv_d       = 1'b0;
      if (captured_q == 4'b1111) begin
         bcd_d      = shadow_q;
         dpm_d      = dps_q;
         fv_d       = 1'b1;
         captured_d = 4'b0000;
      end
      // Applied after the copy so a same-cycle accept seeds the next frame
      if (accept) begin
         shadow_d[{slot, 2'b00} +: 4] = nib;
         dps_d[slot]                  = dp_n;
         captured_d[slot]             = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1_q   <= '0;
         seg_s2_q   <= '0;
         dp_s1_q    <= 1'b0;
         dp_s2_q    <= 1'b0;
         an_s1_q    <= '0;
         an_s2_q    <= '0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         rec_q      <= '0;
         shadow_q   <= '0;
         dps_q      <= '0;
         captured_q <= '0;
         bcd_q      <= '0;
         dpm_q      <= '0;
         fv_q       <= 1'b0;
      end else begin
         seg_s1_q   <= seg_in;
         seg_s2_q   <= seg_s1_q;
         dp_s1_q    <= dp_in;
         dp_s2_q    <= dp_s1_q;
         an_s1_q    <= an_in;
         an_s2_q    <= an_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rec_q      <= rec_d;
         shadow_q   <= shadow_d;
         dps_q      <= dps_d;
         captured_q <= captured_d;
         bcd_q      <= bcd_d;
         dpm_q      <= dpm_d;
         fv_q       <= fv_d;
      end
   end

   assign bcd         = bcd_q;
   assign dp_mask     = dpm_q;
   assign frame_valid = fv_q;

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else if (accept && (nib == NibErr)) err_q <= 1'b1;
   end

   assign pattern_err = err_q;
`else
   assign pattern_err = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with default parameters (active-low, STABLE_CYCLES = 4).
module tb_seven_seg_capture;
   import seven_seg_capture_pkg::*;

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_in = 7'h7F;
   logic        dp_in = 1'b1;
   logic [3:0]  an_in = 4'hF;
   logic [15:0] bcd;
   logic [3:0]  dp_mask;
   logic        frame_valid;
   logic        pattern_err;

   int   vec = 0;
   int   miss = 0;
   int   fv_count = 0;
   logic fv_prev = 1'b0;

   seven_seg_capture dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .dp_in       (dp_in),
      .an_in       (an_in),
      .bcd         (bcd),
      .dp_mask     (dp_mask),
      .frame_valid (frame_valid),
      .pattern_err (pattern_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && frame_valid) begin
         fv_count++;
         vec++;
         if (fv_prev) begin
            miss++;
            $display("FAIL frame_valid_width: high on two consecutive cycles, required one");
         end
      end
      fv_prev = frame_valid && !rst;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic show_digit(input int k, input logic [6:0] pat, input logic dp, input int cyc);
      logic [3:0] oh;
      oh     = 4'b0001 << k;
      an_in  = ~oh;
      seg_in = ~pat;
      dp_in  = ~dp;
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   task automatic blank(input int cyc);
      an_in  = 4'hF;
      seg_in = 7'h7F;
      dp_in  = 1'b1;
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      blank(3);
      vec += 5;
      if (bcd !== 16'h0000) begin miss++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
      if (dp_mask !== 4'h0) begin miss++; $display("FAIL reset_dp_mask: got %b want 0000", dp_mask); end
      if (frame_valid !== 1'b0) begin miss++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
      if (pattern_err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", pattern_err); end
      if (dut.state_q !== StIdle) begin miss++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
      rst = 1'b0;
      blank(2);
   endtask

   task automatic test_basic_frame();
      int fv0;
      fv0 = fv_count;
      show_digit(3, SegPat4, 1'b0, 8);
      show_digit(2, SegPat3, 1'b0, 8);
      show_digit(1, SegPat2, 1'b0, 8);
      show_digit(0, SegPat1, 1'b0, 8);
      blank(6);
      vec += 4;
      if (fv_count - fv0 !== 1) begin miss++; $display("FAIL basic_fv_count: got %0d want 1", fv_count - fv0); end
      if (bcd !== 16'h4321) begin miss++; $display("FAIL basic_bcd: got %h want 4321", bcd); end
      if (dp_mask !== 4'b0000) begin miss++; $display("FAIL basic_dp: got %b want 0000", dp_mask); end
      if (dut.captured_q !== 4'b0000) begin miss++; $display("FAIL basic_captured: got %b want 0000", dut.captured_q); end
   endtask

   task automatic test_short_hold();
      int fv0;
      fv0 = fv_count;
      show_digit(3, SegPat9, 1'b0, 8);
      show_digit(2, SegPat8, 1'b0, 8);
      show_digit(1, SegPat7, 1'b0, 8);
      show_digit(0, SegPat6, 1'b0, 3);
      blank(6);
      vec += 3;
      if (fv_count !== fv0) begin miss++; $display("FAIL short_fv: got %0d pulses want 0", fv_count - fv0); end
      if (dut.captured_q !== 4'b1110) begin miss++; $display("FAIL short_captured: got %b want 1110", dut.captured_q); end
      if (bcd !== 16'h4321) begin miss++; $display("FAIL short_bcd_held: got %h want 4321", bcd); end
      show_digit(0, SegPat6, 1'b0, 4);
      blank(6);
      vec += 2;
      if (fv_count - fv0 !== 1) begin miss++; $display("FAIL short4_fv: got %0d want 1", fv_count - fv0); end
      if (bcd !== 16'h9876) begin miss++; $display("FAIL short4_bcd: got %h want 9876", bcd); end
   endtask

   task automatic test_multi_anode();
      int fv0;
      fv0 = fv_count;
      show_digit(1, SegPat2, 1'b0, 8);
      an_in  = 4'b0011;
      seg_in = ~SegPat5;
      dp_in  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 7; i++) begin
         vec++;
         if (dut.state_q !== StIdle) begin
            miss++;
            $display("FAIL multi_state: cycle %0d got %0d want IDLE", i, dut.state_q);
         end
         @(posedge clk);
         #1;
      end
      vec += 2;
      if (dut.captured_q !== 4'b0010) begin miss++; $display("FAIL multi_captured: got %b want 0010", dut.captured_q); end
      if (fv_count !== fv0) begin miss++; $display("FAIL multi_fv: got %0d pulses want 0", fv_count - fv0); end
      show_digit(3, SegPat0, 1'b0, 8);
      show_digit(2, SegPat5, 1'b0, 8);
      show_digit(0, SegPatBlank, 1'b0, 8);
      blank(6);
      vec += 2;
      if (fv_count - fv0 !== 1) begin miss++; $display("FAIL multi_fv_after: got %0d want 1", fv_count - fv0); end
      if (bcd !== 16'h052A) begin miss++; $display("FAIL multi_bcd: got %h want 052a", bcd); end
   endtask

   task automatic test_pattern_err();
      show_digit(3, SegPat3, 1'b0, 8);
      show_digit(2, 7'h49, 1'b0, 8);
      show_digit(1, SegPat7, 1'b0, 8);
      show_digit(0, SegPat0, 1'b0, 8);
      blank(6);
      vec += 3;
      if (bcd[11:8] !== 4'hF) begin miss++; $display("FAIL err_nibble: got %h want f", bcd[11:8]); end
      if (bcd !== 16'h3F70) begin miss++; $display("FAIL err_bcd: got %h want 3f70", bcd); end
      if (pattern_err !== ErrEn) begin miss++; $display("FAIL err_flag: got %b want %b", pattern_err, ErrEn); end
      show_digit(2, SegPat1, 1'b0, 8);
      blank(10);
      vec++;
      if (pattern_err !== ErrEn) begin miss++; $display("FAIL err_sticky: got %b want %b", pattern_err, ErrEn); end
   endtask

   task automatic test_reset_mid_frame();
      int fv0;
      show_digit(3, SegPat1, 1'b0, 8);
      show_digit(2, SegPat2, 1'b0, 8);
      show_digit(1, SegPat3, 1'b0, 8);
      rst = 1'b1;
      blank(2);
      vec += 4;
      if (bcd !== 16'h0000) begin miss++; $display("FAIL rstmid_bcd: got %h want 0000", bcd); end
      if (dut.captured_q !== 4'b0000) begin miss++; $display("FAIL rstmid_captured: got %b want 0000", dut.captured_q); end
      if (pattern_err !== 1'b0) begin miss++; $display("FAIL rstmid_err: got %b want 0", pattern_err); end
      if (dut.state_q !== StIdle) begin miss++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q); end
      rst = 1'b0;
      blank(2);
      fv0 = fv_count;
      show_digit(0, SegPat9, 1'b0, 8);
      blank(6);
      vec += 3;
      if (fv_count !== fv0) begin miss++; $display("FAIL rstmid_fv_early: got %0d pulses want 0", fv_count - fv0); end
      if (dut.captured_q !== 4'b0001) begin miss++; $display("FAIL rstmid_captured1: got %b want 0001", dut.captured_q); end
      if (bcd !== 16'h0000) begin miss++; $display("FAIL rstmid_bcd_held: got %h want 0000", bcd); end
      show_digit(3, SegPat8, 1'b0, 8);
      show_digit(2, SegPat4, 1'b0, 8);
      show_digit(1, SegPat6, 1'b0, 8);
      show_digit(0, SegPat9, 1'b0, 8);
      blank(6);
      vec += 2;
      if (fv_count - fv0 !== 1) begin miss++; $display("FAIL rstmid_fv: got %0d want 1", fv_count - fv0); end
      if (bcd !== 16'h8469) begin miss++; $display("FAIL rstmid_bcd_new: got %h want 8469", bcd); end
   endtask

   task automatic test_dp_scan();
      int fv0;
      fv0 = fv_count;
      for (int f = 0; f < 2; f++) begin
         show_digit(3, SegPat1, 1'b0, 8);
         show_digit(2, SegPat2, 1'b1, 8);
         show_digit(1, SegPat3, 1'b0, 8);
         show_digit(0, SegPat4, 1'b0, 8);
      end
      blank(6);
      vec += 3;
      if (fv_count - fv0 !== 2) begin miss++; $display("FAIL dp_fv_count: got %0d want 2", fv_count - fv0); end
      if (dp_mask !== 4'b0100) begin miss++; $display("FAIL dp_mask: got %b want 0100", dp_mask); end
      if (bcd !== 16'h1234) begin miss++; $display("FAIL dp_bcd: got %h want 1234", bcd); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_short_hold();
      test_multi_anode();
      test_pattern_err();
      test_reset_mid_frame();
      test_dp_scan();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
